// File: rtl/riscv_data_mem_bridge_if.sv
// Core-side data bus (req/gnt/rvalid protocol) between the core's load/store unit and the SRAM bridge.
// The core drives the master modport, the bridge takes the slave modport.
interface riscv_data_mem_bridge_if;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_err_o;

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
  );
endinterface

// File: rtl/riscv_data_mem_bridge.sv
// Bridge from the core data port to a one-cycle-latency single-port SRAM.
// Adds programmable grant wait states, an address-window bus error and byte-enabled writes.
module riscv_data_mem_bridge #(
  parameter logic [31:0] ADDR_BASE   = 32'h0010_0000,
  parameter int          MEM_WORDS   = 16384,
  parameter int          WAIT_CYCLES = 0,
  localparam int         AW          = $clog2(MEM_WORDS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  riscv_data_mem_bridge_if.slave bus,
  output logic                 mem_en_o,
  output logic [3:0]           mem_we_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i
);

  localparam logic [3:0]  WAIT_RELOAD = 4'(WAIT_CYCLES);
  localparam logic [31:0] WIN_BYTES   = 32'(4 * MEM_WORDS);

  logic [3:0]  wcnt_reg;
  logic        rv_reg;
  logic        err_reg;
  logic        rd_reg;
  logic [31:0] offset;
  logic        in_win;
  logic        gnt;
  logic        access;

  // Addresses below the base wrap to large offsets and fall outside the window.
  assign offset = bus.data_addr_i - ADDR_BASE;
  assign in_win = offset < WIN_BYTES;
  assign gnt    = bus.data_req_i & (wcnt_reg == 4'd0);
  assign access = gnt & in_win;

  assign bus.data_gnt_o = gnt;

  assign mem_en_o    = access;
  assign mem_addr_o  = access ? offset[AW+1:2] : '0;
  assign mem_wdata_o = access ? bus.data_wdata_i : 32'h0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte_we
    assign mem_we_o[gi] = access & bus.data_we_i & bus.data_be_i[gi];
  end

  // Counter reloads on idle or grant and saturates at zero while a request waits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wcnt_reg <= WAIT_RELOAD;
    end else if (!bus.data_req_i || gnt) begin
      wcnt_reg <= WAIT_RELOAD;
    end else if (wcnt_reg != 4'd0) begin
      wcnt_reg <= wcnt_reg - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rv_reg  <= 1'b0;
      err_reg <= 1'b0;
      rd_reg  <= 1'b0;
    end else begin
      rv_reg <= gnt;
      if (gnt) begin
        err_reg <= ~in_win;
        rd_reg  <= ~bus.data_we_i & in_win;
      end
    end
  end

  assign bus.data_rvalid_o = rv_reg;
  assign bus.data_err_o    = rv_reg & err_reg;
  assign bus.data_rdata_o  = (rv_reg & rd_reg) ? mem_rdata_i : 32'h0;

endmodule
